// File: rtl/core_mem_seq_pkg.sv
// Shared types and constants for the core/memory sequencer: state encoding,
// the default NOP instruction and the wait-counter sizing helper.
`timescale 1ns/1ps
package core_mem_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_DATA   = 3'd3,
    ST_STEP   = 3'd4,
    ST_FAULT  = 3'd5
  } seq_state_e;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  // The counter must be able to hold the value TIMEOUT_CYCLES itself.
  function automatic int wait_cnt_width(input int timeout_cycles);
    return $clog2(timeout_cycles + 1);
  endfunction

endpackage

// File: rtl/core_mem_sequencer_if.sv
// Request/ack bus between the sequencer (master) and the unified memory (slave).
`timescale 1ns/1ps
interface core_mem_sequencer_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_req_timer.sv
// Wait counter for one outstanding memory request; flags timeout when the
// request has gone TIMEOUT_CYCLES cycles without an ack.
`timescale 1ns/1ps
module mem_req_timer
  import core_mem_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic ack,
  output logic timeout
);

  localparam int              CW       = wait_cnt_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0]   CNT_MAX  = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] count;
  logic          running;

  // Fires during the last permitted cycle so the owner leaves on that edge.
  assign timeout = running && !ack && (count == CNT_LAST);

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count   <= '0;
      running <= 1'b0;
    end else if (start) begin
      count   <= '0;
      running <= 1'b1;
    end else if (running) begin
      if (ack || timeout) begin
        running <= 1'b0;
      end else if (count != CNT_MAX) begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/core_mem_sequencer.sv
// Multi-cycle fetch/decode/data/step sequencer sharing one variable-latency
// memory between instruction fetch and load/store of a single-cycle core.
`timescale 1ns/1ps
module core_mem_sequencer
  import core_mem_seq_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 16,
  parameter logic [31:0] NOP_INSTR      = NOP_INSTR_DEFAULT
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        halt,
  input  logic [31:0]                 core_instr_addr,
  input  logic [31:0]                 core_data_addr,
  input  logic                        core_should_read_mem,
  input  logic                        core_should_write_mem,
  input  logic [31:0]                 core_mem_write_data,
  output logic [31:0]                 instr,
  output logic [31:0]                 mem_read_data,
  output logic                        core_step,
  core_mem_sequencer_if.master        mem,
  output logic                        busy,
  output logic                        bus_error,
  output logic [31:0]                 retired_count
);

  seq_state_e  state_q, state_d;

  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] instr_d, rdata_d;
  logic        step_d, busy_d, err_d;
  logic        timer_start, timeout;

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

  mem_req_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .start   (timer_start),
    .ack     (mem.mem_ack && req_q),
    .timeout (timeout)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every signal assigned here gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    instr_d     = instr;
    rdata_d     = mem_read_data;
    err_d       = bus_error;
    step_d      = 1'b0;
    timer_start = 1'b0;

    unique case (state_q)
      ST_IDLE:   if (!halt) state_d = ST_FETCH;
      ST_FETCH: begin
        if (mem.mem_ack) begin
          instr_d = mem.mem_rdata;
          req_d   = 1'b0;
          state_d = ST_DECODE;
        end else if (timeout) begin
          state_d = ST_FAULT;
        end
      end
      ST_DECODE: begin
        if (core_should_read_mem && core_should_write_mem) begin
          state_d = ST_FAULT;
        end else if (core_should_read_mem || core_should_write_mem) begin
          state_d     = ST_DATA;
          req_d       = 1'b1;
          we_d        = core_should_write_mem;
          addr_d      = core_data_addr;
          wdata_d     = core_mem_write_data;
          timer_start = 1'b1;
        end else begin
          state_d = ST_STEP;
        end
      end
      ST_DATA: begin
        if (mem.mem_ack) begin
          if (!we_q) rdata_d = mem.mem_rdata;
          req_d   = 1'b0;
          state_d = ST_STEP;
        end else if (timeout) begin
          state_d = ST_FAULT;
        end
      end
      ST_STEP:   state_d = halt ? ST_IDLE : ST_FETCH;
      ST_FAULT:  state_d = ST_FAULT;
      default:   state_d = ST_FAULT;
    endcase

    // Entry actions shared by the IDLE and STEP paths into FETCH.
    if (state_d == ST_FETCH && state_q != ST_FETCH) begin
      req_d       = 1'b1;
      we_d        = 1'b0;
      addr_d      = core_instr_addr;
      timer_start = 1'b1;
    end
    if (state_d == ST_STEP) step_d = 1'b1;
    if (state_d == ST_FAULT) begin
      req_d = 1'b0;
      err_d = 1'b1;
    end
    busy_d = !(state_d inside {ST_IDLE, ST_FAULT});
  end

  // Outputs are registered from next-state values so they line up with state_q.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_q         <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      instr         <= NOP_INSTR;
      mem_read_data <= '0;
      core_step     <= 1'b0;
      busy          <= 1'b0;
      bus_error     <= 1'b0;
      retired_count <= '0;
    end else begin
      req_q         <= req_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      instr         <= instr_d;
      mem_read_data <= rdata_d;
      core_step     <= step_d;
      busy          <= busy_d;
      bus_error     <= err_d;
      if (step_d) retired_count <= retired_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_core_mem_sequencer.sv
// Directed self-checking bench for core_mem_sequencer (TIMEOUT_CYCLES = 4);
// the bench plays both the core and the memory, step by step.
`timescale 1ns/1ps
module tb_core_mem_sequencer;
  import core_mem_seq_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        halt;
  logic [31:0] core_instr_addr, core_data_addr, core_mem_write_data;
  logic        core_should_read_mem, core_should_write_mem;
  logic [31:0] instr, mem_read_data, retired_count;
  logic        core_step, busy, bus_error;

  int total = 0;
  int bad   = 0;

  core_mem_sequencer_if mem_bus ();

  core_mem_sequencer #(.TIMEOUT_CYCLES(4)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .halt                  (halt),
    .core_instr_addr       (core_instr_addr),
    .core_data_addr        (core_data_addr),
    .core_should_read_mem  (core_should_read_mem),
    .core_should_write_mem (core_should_write_mem),
    .core_mem_write_data   (core_mem_write_data),
    .instr                 (instr),
    .mem_read_data         (mem_read_data),
    .core_step             (core_step),
    .mem                   (mem_bus.master),
    .busy                  (busy),
    .bus_error             (bus_error),
    .retired_count         (retired_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " instr"},         instr, NOP);
    check({tag, " mem_req"},       32'(mem_bus.mem_req), 32'd0);
    check({tag, " mem_we"},        32'(mem_bus.mem_we), 32'd0);
    check({tag, " core_step"},     32'(core_step), 32'd0);
    check({tag, " busy"},          32'(busy), 32'd0);
    check({tag, " bus_error"},     32'(bus_error), 32'd0);
    check({tag, " mem_read_data"}, mem_read_data, 32'd0);
    check({tag, " retired"},       retired_count, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; halt = 1'b1;
    core_instr_addr = '0; core_data_addr = '0; core_mem_write_data = '0;
    core_should_read_mem = 1'b0; core_should_write_mem = 1'b0;
    mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = '0;

    // Reset state, then parked in IDLE while halt is high.
    #12;
    check_reset_values("reset");
    @(negedge clk) reset = 1'b1;
    tick(); tick();
    check("halt idle busy", 32'(busy), 32'd0);
    check("halt idle req",  32'(mem_bus.mem_req), 32'd0);

    // Non-memory instruction: FETCH, DECODE, STEP.
    halt = 1'b0; core_instr_addr = 32'h0;
    tick();
    check("t1 fetch req",  32'(mem_bus.mem_req), 32'd1);
    check("t1 fetch we",   32'(mem_bus.mem_we), 32'd0);
    check("t1 fetch addr", mem_bus.mem_addr, 32'h0);
    check("t1 fetch busy", 32'(busy), 32'd1);
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h0050_0093; halt = 1'b1;
    tick();
    check("t1 decode instr", instr, 32'h0050_0093);
    check("t1 decode req",   32'(mem_bus.mem_req), 32'd0);
    check("t1 decode step",  32'(core_step), 32'd0);
    mem_bus.mem_ack = 1'b0;
    tick();
    check("t1 step pulse",   32'(core_step), 32'd1);
    check("t1 retired",      retired_count, 32'd1);
    tick();
    check("t1 idle step",    32'(core_step), 32'd0);
    check("t1 idle busy",    32'(busy), 32'd0);

    // Load with 3 wait cycles in DATA: 7 cycles to core_step.
    halt = 1'b0; core_instr_addr = 32'h4;
    tick();                                                   // cycle 1
    check("ld fetch addr", mem_bus.mem_addr, 32'h4);
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h1000_2083;
    tick();                                                   // cycle 2
    check("ld decode instr", instr, 32'h1000_2083);
    mem_bus.mem_ack = 1'b0; core_should_read_mem = 1'b1; core_data_addr = 32'h100;
    tick();                                                   // cycle 3
    check("ld data req",  32'(mem_bus.mem_req), 32'd1);
    check("ld data we",   32'(mem_bus.mem_we), 32'd0);
    check("ld data addr", mem_bus.mem_addr, 32'h100);
    tick();                                                   // cycle 4
    check("ld wait1 step", 32'(core_step), 32'd0);
    tick();                                                   // cycle 5
    check("ld wait2 req",  32'(mem_bus.mem_req), 32'd1);
    tick();                                                   // cycle 6
    check("ld wait3 err",  32'(bus_error), 32'd0);
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'hDEAD_BEEF;
    core_instr_addr = 32'h8;
    tick();                                                   // cycle 7
    check("ld step pulse", 32'(core_step), 32'd1);
    check("ld rdata",      mem_read_data, 32'hDEAD_BEEF);
    check("ld retired",    retired_count, 32'd2);
    check("ld step req",   32'(mem_bus.mem_req), 32'd0);
    mem_bus.mem_ack = 1'b0; core_should_read_mem = 1'b0;

    // Store straight after, with halt raised mid-DATA.
    tick();
    check("st fetch addr", mem_bus.mem_addr, 32'h8);
    check("st fetch step", 32'(core_step), 32'd0);
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h2020_2023;
    tick();
    check("st decode instr", instr, 32'h2020_2023);
    mem_bus.mem_ack = 1'b0; core_should_write_mem = 1'b1;
    core_data_addr = 32'h200; core_mem_write_data = 32'hA5A5_A5A5;
    tick();
    check("st data we",    32'(mem_bus.mem_we), 32'd1);
    check("st data addr",  mem_bus.mem_addr, 32'h200);
    check("st data wdata", mem_bus.mem_wdata, 32'hA5A5_A5A5);
    core_data_addr = 32'h0; core_mem_write_data = 32'h0; halt = 1'b1;
    tick();
    check("st hold addr",  mem_bus.mem_addr, 32'h200);
    check("st hold wdata", mem_bus.mem_wdata, 32'hA5A5_A5A5);
    check("st hold req",   32'(mem_bus.mem_req), 32'd1);
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h1234_5678;
    tick();
    check("st step pulse", 32'(core_step), 32'd1);
    check("st rdata kept", mem_read_data, 32'hDEAD_BEEF);
    check("st retired",    retired_count, 32'd3);
    mem_bus.mem_ack = 1'b0; core_should_write_mem = 1'b0;
    tick();
    check("st halt busy",  32'(busy), 32'd0);
    check("st halt step",  32'(core_step), 32'd0);
    check("st halt retired", retired_count, 32'd3);

    // Stray ack in IDLE changes nothing.
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'hFFFF_FFFF;
    tick();
    check("idle ack instr", instr, 32'h2020_2023);
    check("idle ack busy",  32'(busy), 32'd0);
    mem_bus.mem_ack = 1'b0;

    // Asynchronous reset in the middle of FETCH.
    halt = 1'b0; core_instr_addr = 32'hC;
    tick();
    check("rst fetch req", 32'(mem_bus.mem_req), 32'd1);
    #2 reset = 1'b0;
    #1 check_reset_values("async rst");
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'hBAD0_BAD0;
    tick();
    check_reset_values("rst held");
    mem_bus.mem_ack = 1'b0; halt = 1'b1;
    @(negedge clk) reset = 1'b1;
    tick();
    check("rst release busy", 32'(busy), 32'd0);

    // Fetch timeout: 4 request cycles without ack, then sticky FAULT.
    halt = 1'b0; core_instr_addr = 32'h10;
    tick();
    check("to cycle1 req", 32'(mem_bus.mem_req), 32'd1);
    halt = 1'b1;
    tick(); tick(); tick();
    check("to cycle4 req", 32'(mem_bus.mem_req), 32'd1);
    check("to cycle4 err", 32'(bus_error), 32'd0);
    tick();
    check("to fault err",  32'(bus_error), 32'd1);
    check("to fault req",  32'(mem_bus.mem_req), 32'd0);
    check("to fault busy", 32'(busy), 32'd0);
    check("to fault step", 32'(core_step), 32'd0);
    mem_bus.mem_ack = 1'b1; halt = 1'b0;
    tick(); tick();
    check("to sticky err",     32'(bus_error), 32'd1);
    check("to sticky req",     32'(mem_bus.mem_req), 32'd0);
    check("to sticky retired", retired_count, 32'd0);
    check("to sticky instr",   instr, NOP);
    mem_bus.mem_ack = 1'b0;

    // Illegal decode: read and write both requested.
    reset = 1'b0; halt = 1'b1;
    #3 check("ill reset err", 32'(bus_error), 32'd0);
    @(negedge clk) reset = 1'b1;
    halt = 1'b0; core_instr_addr = 32'h20;
    tick();
    check("ill fetch addr", mem_bus.mem_addr, 32'h20);
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h0000_0003;
    tick();
    mem_bus.mem_ack = 1'b0;
    core_should_read_mem = 1'b1; core_should_write_mem = 1'b1;
    tick();
    check("ill fault err",  32'(bus_error), 32'd1);
    check("ill fault req",  32'(mem_bus.mem_req), 32'd0);
    check("ill fault step", 32'(core_step), 32'd0);
    check("ill retired",    retired_count, 32'd0);
    core_should_read_mem = 1'b0; core_should_write_mem = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
